unpacked_serializer: RTL and testbench
======================================

# unpacked_serializer

Width-reducing stage that accepts one vector of IN_NUM elements per handshake and emits it as IN_NUM/OUT_NUM consecutive beats of OUT_NUM elements each.

- Sits directly downstream of the unpacked FIFO and narrows its wide vector output for a compute core with fewer lanes.
- Uses the same valid/ready handshake on both sides and supports back-to-back vectors with no bubble cycles.

## Interface

Parameters:

- DATA_WIDTH, 8, width of one element.
- IN_NUM, 8, elements per input vector.
- OUT_NUM, 2, elements per output beat. IN_NUM % OUT_NUM must equal 0; elaboration fails otherwise.
- BEATS (local), IN_NUM/OUT_NUM.
- CNT_W (local), max(1, $clog2(BEATS)).

Ports:

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- data_in  input  DATA_WIDTH x [IN_NUM-1:0] unpacked  input vector.
- data_in_valid  input  1  input vector valid.
- data_in_ready  output  1  block accepts data_in this cycle.
- data_out  output  DATA_WIDTH x [OUT_NUM-1:0] unpacked  current beat.
- data_out_valid  output  1  beat valid.
- data_out_ready  input  1  downstream accepts beat.
- data_out_last  output  1  current beat is the final beat (index BEATS-1) of its vector.

## Operation

- Internal state:
  - buf[IN_NUM-1:0], the holding register.
  - busy, set when buf holds a vector with beats still to send.
  - cnt[CNT_W-1:0], the index of the beat currently presented.
- Two states:
  - IDLE (busy=0): data_in_ready=1, data_out_valid=0.
  - BUSY (busy=1): data_out_valid=1.
- Beat k drives data_out[j] = buf[k*OUT_NUM + j] for j in 0..OUT_NUM-1. Lowest-index elements go first.
- data_out_last = busy && (cnt == BEATS-1).
- data_in_ready = !busy || (data_out_last && data_out_ready). This is a combinational path from data_out_ready, which is accepted by design.
- Input accept (data_in_valid && data_in_ready):
  - buf <= data_in, cnt <= 0, busy <= 1.
  - This holds whether the block was IDLE or was finishing its last beat in the same cycle.
- Output accept (data_out_valid && data_out_ready), not on the last beat: cnt <= cnt+1.
- Output accept on the last beat with no input accept: busy <= 0, cnt <= 0.
- Stall (data_out_valid && !data_out_ready): buf, cnt and data_out hold stable. data_out_valid stays high and is never withdrawn.
- BEATS == 1: the block degenerates to a one-entry skid-free register stage. data_out_last equals data_out_valid.
- No element reordering, dropping or duplication. Every accepted vector produces exactly BEATS output handshakes.

## Timing

- Reset values, applied asynchronously while rst=1: busy=0, cnt=0, buf=0, data_out_valid=0, data_out_last=0, data_out=0.
- data_in_ready is forced to 0 while rst=1. It reads 1 from the first cycle after rst deasserts.
- Latency: a vector accepted at edge t presents beat 0 with data_out_valid=1 in the cycle following t.
- Throughput with data_out_ready held high is one vector per BEATS cycles, at 100% output-beat utilisation. The next vector loads on the same edge the last beat is taken.
- Final beat stalled (data_out_ready=0): data_in_ready=0, so no new vector overwrites buf.
- Reset mid-vector: the partial vector is discarded. Outputs return to reset values asynchronously. No beat is emitted after rst deasserts until a new vector is accepted.
- Input side: data_in is sampled only on an accepting edge. data_in_valid may drop without acceptance, since upstream FIFO semantics own that rule.

## Test plan

- **Single vector.** IN_NUM=8, OUT_NUM=2, data_in={7,6,5,4,3,2,1,0} (index 7..0), data_out_ready=1.
  - Four beats: {1,0}, {3,2}, {5,4}, {7,6} on consecutive cycles.
  - data_out_last=1 only on {7,6}; data_in_ready=0 during beats 0-2.
- **Back-to-back.** Two vectors, A elements 0x00-0x07 and B elements 0x10-0x17, with data_in_valid held high.
  - Eight consecutive valid beats with no gap; B's beat 0 {0x11,0x10} immediately follows A's {0x07,0x06}.
- **Stall on last beat.** data_out_ready=0 for 3 cycles while beat 3 is shown.
  - data_out stays {7,6}, data_out_last=1, data_in_ready=0 throughout.
  - On release, data_in_ready=1 in the same cycle.
- **Random backpressure.** 1000 random vectors with 50% random data_out_ready.
  - The scoreboard sees an exactly ordered element stream with no loss or duplication.
  - data_out is stable under every stall.
- **Reset mid-vector.** Assert rst asynchronously (between edges) after beat 1 is accepted.
  - data_out_valid drops immediately; after release, data_in_ready=1, and no stale beats {5,4} or {7,6} appear.
- **BEATS=1 config.** IN_NUM=OUT_NUM=4.
  - Each vector appears one cycle after acceptance with data_out_last=1.
  - Sustains one vector per cycle with data_out_ready=1.

Source files
------------

// File: rtl/unpacked_serializer_if.sv
// ---------------------------------------------------------------------------
// unpacked_serializer_if
//
// Bundles both handshake sides of the unpacked serializer.
//   data_in        [IN_NUM]  elements   wide vector from upstream
//   data_in_valid / data_in_ready       input-side handshake
//   data_out       [OUT_NUM] elements   current narrow beat
//   data_out_valid / data_out_ready     output-side handshake
//   data_out_last                       final beat of the current vector
//
// Handshake rule for both sides: a transfer happens on a rising clk edge
// where valid && ready are both 1. Once valid is raised, the producer keeps
// valid and its data stable until that transfer happens.
// The upstream FIFO owns the input side, so it may drop data_in_valid
// without a transfer.
//
// Modports:
//   slave  - the serializer itself
//   master - the environment: drives data_in and data_out_ready
// ---------------------------------------------------------------------------
interface unpacked_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int OUT_NUM    = 2
);
  logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [OUT_NUM-1:0];
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready,
    output data_out,
    output data_out_valid,
    output data_out_last,
    input  data_out_ready
  );

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready,
    input  data_out,
    input  data_out_valid,
    input  data_out_last,
    output data_out_ready
  );
endinterface

// File: rtl/unpacked_serializer.sv
// ---------------------------------------------------------------------------
// unpacked_serializer
//
// Accepts one vector of IN_NUM elements per input handshake. It then emits
// that vector as BEATS = IN_NUM/OUT_NUM consecutive beats of OUT_NUM elements.
// The lowest-index elements go out first. A new vector loads on the same edge
// that the last beat is taken, so back-to-back vectors leave no bubble.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   bus        unpacked_serializer_if.slave (both handshake sides)
//   state_dbg  current FSM state (0 = IDLE, 1 = BUSY)
// ---------------------------------------------------------------------------
module unpacked_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int OUT_NUM    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  unpacked_serializer_if.slave bus,
  output logic [0:0]           state_dbg
);

  localparam int BEATS = IN_NUM / OUT_NUM;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if ((IN_NUM % OUT_NUM) != 0) begin : g_bad_ratio
      $error("unpacked_serializer: IN_NUM must be a multiple of OUT_NUM");
    end
  endgenerate

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] buf_q [IN_NUM-1:0];

  logic busy;
  logic last_beat;
  logic in_acc;
  logic out_acc;

  assign busy      = (state == BUSY);
  assign last_beat = busy && (cnt == LAST_CNT);
  assign out_acc   = busy && bus.data_out_ready;

  // The last beat leaving on this edge frees buf_q for the next vector.
  // This makes data_in_ready combinational from data_out_ready. It is also
  // held low during reset, so nothing can load while the block is cleared.
  assign bus.data_in_ready = !rst && (!busy || (last_beat && bus.data_out_ready));
  assign in_acc            = bus.data_in_valid && bus.data_in_ready;

  assign bus.data_out_valid = busy;
  assign bus.data_out_last  = last_beat;
  assign state_dbg          = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < IN_NUM; i++) begin
        buf_q[i] <= '0;
      end
    end else if (in_acc) begin
      // This covers both a load from IDLE and a load on the last-beat edge.
      buf_q <= bus.data_in;
      cnt   <= '0;
      state <= BUSY;
    end else if (out_acc) begin
      if (last_beat) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Beat mux. The beat indices are constants, so every buf_q select is static.
  // Counter values at or above BEATS never occur; they fall back to zero.
  always_comb begin
    for (int j = 0; j < OUT_NUM; j++) begin
      bus.data_out[j] = '0;
    end
    for (int k = 0; k < BEATS; k++) begin
      if (cnt == CNT_W'(k)) begin
        for (int j = 0; j < OUT_NUM; j++) begin
          bus.data_out[j] = buf_q[k*OUT_NUM + j];
        end
      end
    end
  end

endmodule

// File: tb/tb_unpacked_serializer.sv
// ---------------------------------------------------------------------------
// tb_unpacked_serializer
//
// Bench for two instances of unpacked_serializer:
//   dut8  8 elements in, 2 per beat (4 beats per vector)
//   dut4  4 elements in, 4 per beat (1 beat per vector)
// Inputs change 1 ns after the rising edge. The monitors sample on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_unpacked_serializer;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unpacked_serializer_if #(.DATA_WIDTH(DW), .IN_NUM(8), .OUT_NUM(2)) bus8 ();
  unpacked_serializer_if #(.DATA_WIDTH(DW), .IN_NUM(4), .OUT_NUM(4)) bus4 ();
  logic [0:0] state8;
  logic [0:0] state4;

  unpacked_serializer #(.DATA_WIDTH(DW), .IN_NUM(8), .OUT_NUM(2)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .state_dbg(state8)
  );
  unpacked_serializer #(.DATA_WIDTH(DW), .IN_NUM(4), .OUT_NUM(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .state_dbg(state4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp8_q[$];
  logic [DW-1:0] exp4_q[$];

  // ---------------- clock / drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++) bus8.data_in[i] = base + DW'(i);
  endtask

  task automatic load4(input logic [DW-1:0] base);
    for (int i = 0; i < 4; i++) bus4.data_in[i] = base + DW'(i);
  endtask

  // ---------------- scoreboard monitors ----------------
  int            beat8;
  logic          stall8;
  logic [DW-1:0] prev8 [2];

  always @(negedge clk) begin
    if (rst) begin
      exp8_q.delete();
      beat8  = 0;
      stall8 = 1'b0;
    end else begin
      if (stall8) begin
        n_checks++;
        if (bus8.data_out_valid !== 1'b1 || bus8.data_out[0] !== prev8[0] ||
            bus8.data_out[1] !== prev8[1]) begin
          n_fail++;
          $display("FAIL stall8_stable: got v=%b {%h,%h} expected v=1 {%h,%h}",
                   bus8.data_out_valid, bus8.data_out[1], bus8.data_out[0], prev8[1], prev8[0]);
        end
      end
      if (bus8.data_out_valid && bus8.data_out_ready) begin
        n_checks++;
        if (exp8_q.size() < 2) begin
          n_fail++;
          $display("FAIL sb8_unexpected: got beat {%h,%h} expected no beat",
                   bus8.data_out[1], bus8.data_out[0]);
        end else begin
          for (int j = 0; j < 2; j++) begin
            logic [DW-1:0] e;
            e = exp8_q.pop_front();
            if (j > 0) n_checks++;
            if (bus8.data_out[j] !== e) begin
              n_fail++;
              $display("FAIL sb8_data[%0d]: got %h expected %h", j, bus8.data_out[j], e);
            end
          end
        end
        n_checks++;
        if (bus8.data_out_last !== (beat8 == 3)) begin
          n_fail++;
          $display("FAIL sb8_last: got %b expected %b", bus8.data_out_last, (beat8 == 3));
        end
        beat8 = (beat8 == 3) ? 0 : beat8 + 1;
      end
      if (bus8.data_in_valid && bus8.data_in_ready) begin
        for (int i = 0; i < 8; i++) exp8_q.push_back(bus8.data_in[i]);
      end
      stall8   = bus8.data_out_valid && !bus8.data_out_ready;
      prev8[0] = bus8.data_out[0];
      prev8[1] = bus8.data_out[1];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp4_q.delete();
    end else begin
      if (bus4.data_out_valid && bus4.data_out_ready) begin
        n_checks++;
        if (exp4_q.size() < 4) begin
          n_fail++;
          $display("FAIL sb4_unexpected: got beat %h expected no beat", bus4.data_out[0]);
        end else begin
          for (int j = 0; j < 4; j++) begin
            logic [DW-1:0] e;
            e = exp4_q.pop_front();
            if (j > 0) n_checks++;
            if (bus4.data_out[j] !== e) begin
              n_fail++;
              $display("FAIL sb4_data[%0d]: got %h expected %h", j, bus4.data_out[j], e);
            end
          end
        end
        n_checks++;
        if (bus4.data_out_last !== 1'b1) begin
          n_fail++;
          $display("FAIL sb4_last: got %b expected 1", bus4.data_out_last);
        end
      end
      if (bus4.data_in_valid && bus4.data_in_ready) begin
        for (int i = 0; i < 4; i++) exp4_q.push_back(bus4.data_in[i]);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [20:0] got;
    #2;
    n_checks++;
    got = {bus8.data_out[1], bus8.data_out[0], bus8.data_out_valid, bus8.data_out_last,
           bus8.data_in_ready, state8, bus4.data_out_valid, bus4.data_in_ready};
    if (got !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", got, 21'd0);
    end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus8.data_in_ready, bus4.data_in_ready, bus8.data_out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: got rdy8=%b rdy4=%b v8=%b expected 1 1 0",
               bus8.data_in_ready, bus4.data_in_ready, bus8.data_out_valid);
    end
    tick();
  endtask

  task automatic test_single();
    logic [19:0] got, exp;
    load8(8'h00);
    bus8.data_in_valid  = 1'b1;
    bus8.data_out_ready = 1'b1;
    tick();
    bus8.data_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = {bus8.data_out[1], bus8.data_out[0], bus8.data_out_valid, bus8.data_out_last,
             bus8.data_in_ready, state8};
      exp = {DW'(2*k+1), DW'(2*k), 1'b1, (k == 3), (k == 3), 1'b1};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %h expected %h", k, got, exp);
      end
      tick();
    end
    n_checks++;
    if ({bus8.data_out_valid, state8} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got v=%b st=%b expected 0 0", bus8.data_out_valid, state8);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] got, exp;
    logic [DW-1:0] b, e0;
    load8(8'h00);
    bus8.data_in_valid  = 1'b1;
    bus8.data_out_ready = 1'b1;
    tick();
    load8(8'h10);
    for (int k = 0; k < 8; k++) begin
      b  = (k < 4) ? 8'h00 : 8'h10;
      e0 = b + DW'((k % 4) * 2);
      got = {bus8.data_out[1], bus8.data_out[0], bus8.data_out_valid, bus8.data_in_ready,
             bus8.data_out_last};
      exp = {e0 + 8'd1, e0, 1'b1, ((k % 4) == 3), ((k % 4) == 3)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got %h expected %h", k, got, exp);
      end
      if (k == 4) bus8.data_in_valid = 1'b0;
      tick();
    end
    n_checks++;
    if (bus8.data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got v=%b expected 0", bus8.data_out_valid);
    end
  endtask

  task automatic test_stall_last();
    logic [18:0] got, exp;
    load8(8'h00);
    bus8.data_in_valid  = 1'b1;
    bus8.data_out_ready = 1'b1;
    tick();
    bus8.data_in_valid = 1'b0;
    load8(8'h20);
    repeat (3) tick();
    bus8.data_out_ready = 1'b0;
    bus8.data_in_valid  = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      got = {bus8.data_out[1], bus8.data_out[0], bus8.data_out_valid, bus8.data_out_last,
             bus8.data_in_ready};
      exp = {8'd7, 8'd6, 1'b1, 1'b1, 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got %h expected %h", s, got, exp);
      end
      tick();
    end
    bus8.data_out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus8.data_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b expected 1", bus8.data_in_ready);
    end
    tick();
    bus8.data_in_valid = 1'b0;
    n_checks++;
    if ({bus8.data_out[1], bus8.data_out[0], bus8.data_out_valid} !== {8'h21, 8'h20, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_next_vec: got {%h,%h} v=%b expected {21,20} v=1",
               bus8.data_out[1], bus8.data_out[0], bus8.data_out_valid);
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    int   acc_cnt = 0;
    int   cyc     = 0;
    logic acc;
    for (int i = 0; i < 8; i++) bus8.data_in[i] = DW'($urandom_range(0, 255));
    while (acc_cnt < 1000 && cyc < 40000) begin
      bus8.data_in_valid  = ($urandom_range(0, 3) != 0);
      bus8.data_out_ready = $urandom_range(0, 1) ? 1'b1 : 1'b0;
      #1;
      acc = bus8.data_in_valid && bus8.data_in_ready;
      tick();
      cyc++;
      if (acc) begin
        acc_cnt++;
        for (int i = 0; i < 8; i++) bus8.data_in[i] = DW'($urandom_range(0, 255));
      end
    end
    n_checks++;
    if (acc_cnt != 1000) begin
      n_fail++;
      $display("FAIL random_budget: got %0d vectors expected 1000", acc_cnt);
    end
    bus8.data_in_valid  = 1'b0;
    bus8.data_out_ready = 1'b1;
    cyc = 0;
    while ((exp8_q.size() != 0 || bus8.data_out_valid) && cyc < 100) begin
      tick();
      cyc++;
    end
    tick();
    n_checks++;
    if (exp8_q.size() != 0 || bus8.data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d pending v=%b expected 0 pending v=0",
               exp8_q.size(), bus8.data_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] got;
    load8(8'h00);
    bus8.data_in_valid  = 1'b1;
    bus8.data_out_ready = 1'b1;
    tick();
    bus8.data_in_valid = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({bus8.data_out[1], bus8.data_out[0]} !== {8'd5, 8'd4}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got {%h,%h} expected {05,04}", bus8.data_out[1], bus8.data_out[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus8.data_out[1], bus8.data_out[0], bus8.data_out_valid, bus8.data_out_last,
           bus8.data_in_ready, state8};
    n_checks++;
    if (got !== 20'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected %h", got, 20'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus8.data_in_ready, bus8.data_out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_release: got rdy=%b v=%b expected 1 0",
               bus8.data_in_ready, bus8.data_out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (bus8.data_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale%0d: got v=1 {%h,%h} expected v=0",
                 c, bus8.data_out[1], bus8.data_out[0]);
      end
    end
  endtask

  task automatic test_beats_one();
    logic [34:0] got, exp;
    logic [DW-1:0] b;
    load4(8'h40);
    bus4.data_in_valid  = 1'b1;
    bus4.data_out_ready = 1'b1;
    tick();
    for (int v = 1; v <= 6; v++) begin
      b   = 8'h40 + DW'(4 * (v - 1));
      got = {bus4.data_out[3], bus4.data_out[2], bus4.data_out[1], bus4.data_out[0],
             bus4.data_out_valid, bus4.data_out_last, bus4.data_in_ready};
      exp = {b + 8'd3, b + 8'd2, b + 8'd1, b, 1'b1, 1'b1, 1'b1};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL beats1_vec%0d: got %h expected %h", v - 1, got, exp);
      end
      if (v < 6) load4(8'h40 + DW'(4 * v));
      else       load4(8'h80);
      tick();
    end
    bus4.data_out_ready = 1'b0;
    #1;
    got = {bus4.data_out[3], bus4.data_out[2], bus4.data_out[1], bus4.data_out[0],
           bus4.data_out_valid, bus4.data_out_last, bus4.data_in_ready};
    exp = {8'h83, 8'h82, 8'h81, 8'h80, 1'b1, 1'b1, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL beats1_stall: got %h expected %h", got, exp);
    end
    bus4.data_in_valid  = 1'b0;
    bus4.data_out_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus4.data_out_valid, state4} !== 2'b00) begin
      n_fail++;
      $display("FAIL beats1_idle: got v=%b st=%b expected 0 0", bus4.data_out_valid, state4);
    end
    tick();
  endtask

  initial begin
    rst                 = 1'b1;
    bus8.data_in_valid  = 1'b0;
    bus8.data_out_ready = 1'b0;
    bus4.data_in_valid  = 1'b0;
    bus4.data_out_ready = 1'b0;
    load8(8'h00);
    load4(8'h00);

    test_reset();
    test_single();
    test_back_to_back();
    test_stall_last();
    test_random();
    test_reset_mid();
    test_beats_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
